// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
//   state_e             : FSM states of the stall controller
//   LU_CMP_W            : register-index width used by the load-use compare
//   LOAD_USE_CYCLES_DEF : default bubbles per load-use hazard (legal 1..3)
//   MEM_TIMEOUT_DEF     : default memory-stall watchdog limit (0 disables)
package hazard_pkg;

   localparam int unsigned LU_CMP_W            = 5;
   localparam int unsigned LOAD_USE_CYCLES_DEF = 1;
   localparam int unsigned MEM_TIMEOUT_DEF     = 255;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BUBBLE   = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard sideband between the ID-stage pipeline control and the stall controller.
//   master : pipeline side, drives hazard inputs and consumes enables/stalls
//   slave  : stall controller side
interface hazard_stall_controller_if;
   import hazard_pkg::*;

   logic [LU_CMP_W-1:0] IF_ID_RS1;
   logic [LU_CMP_W-1:0] IF_ID_RS2;
   logic [LU_CMP_W-1:0] ID_EX_RD;
   logic                ID_EX_MemRead;
   logic                Branch_Taken;
   logic                Mem_Stall;

   logic                PC_Write;
   logic                IF_ID_Write;
   logic                IF_ID_Flush;
   logic                ID_EX_Bubble;
   logic                Pipe_Freeze;
   logic                Mem_Timeout;

   modport master (
      output IF_ID_RS1, IF_ID_RS2, ID_EX_RD, ID_EX_MemRead, Branch_Taken, Mem_Stall,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Mem_Timeout
   );

   modport slave (
      input  IF_ID_RS1, IF_ID_RS2, ID_EX_RD, ID_EX_MemRead, Branch_Taken, Mem_Stall,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Mem_Timeout
   );

endinterface

// File: rtl/hazard_perf_counters.sv
// Saturating 32-bit event counters for bubble, freeze and flush cycles.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   bubble_i/freeze_i/flush_i : per-cycle event strobes
//   *_cnt_o            : counter values
module hazard_perf_counters (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bubble_i,
   input  logic        freeze_i,
   input  logic        flush_i,
   output logic [31:0] loaduse_cnt_o,
   output logic [31:0] memstall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   logic [31:0] lu_q, lu_d, ms_q, ms_d, fl_q, fl_d;

   // Increment on event, hold at all-ones.
   always_comb begin
      lu_d = lu_q;
      ms_d = ms_q;
      fl_d = fl_q;
      if (bubble_i && (lu_q != '1)) lu_d = lu_q + 32'd1;
      if (freeze_i && (ms_q != '1)) ms_d = ms_q + 32'd1;
      if (flush_i  && (fl_q != '1)) fl_d = fl_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lu_q <= '0;
         ms_q <= '0;
         fl_q <= '0;
      end else begin
         lu_q <= lu_d;
         ms_q <= ms_d;
         fl_q <= fl_d;
      end
   end

   assign loaduse_cnt_o  = lu_q;
   assign memstall_cnt_o = ms_q;
   assign flush_cnt_o    = fl_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flushes, memory-stall
// freezes and a sticky memory-stall watchdog. Outputs are combinational.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : hazard inputs and PC/IF-ID/ID-EX/freeze controls
//   Perf_*_Cnt   : event counters, present only with HAZARD_PERF_EN defined
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int unsigned LOAD_USE_CYCLES = LOAD_USE_CYCLES_DEF,
   parameter int unsigned MEM_TIMEOUT     = MEM_TIMEOUT_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   hazard_stall_controller_if.slave  bus
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]               Perf_LoadUse_Cnt,
   output logic [31:0]               Perf_MemStall_Cnt,
   output logic [31:0]               Perf_Flush_Cnt
`endif
);

   state_e     state_q, state_d, ret_state_q, ret_state_d, eff_state_c;
   logic [1:0] bub_cnt_q, bub_cnt_d;
   logic [7:0] timer_q, timer_d;
   logic       timeout_q, timeout_d;
   logic       lu_c;

   assign lu_c = bus.ID_EX_MemRead && (bus.ID_EX_RD != '0) &&
                 ((bus.ID_EX_RD == bus.IF_ID_RS1) || (bus.ID_EX_RD == bus.IF_ID_RS2));

   // Leaving MEM_WAIT behaves exactly like the interrupted state would this cycle.
   assign eff_state_c = ((state_q == MEM_WAIT) && !bus.Mem_Stall) ? ret_state_q : state_q;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         ret_state_q <= RUN;
         bub_cnt_q   <= 2'd0;
         timer_q     <= 8'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_state_q <= ret_state_d;
         bub_cnt_q   <= bub_cnt_d;
         timer_q     <= timer_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d     = eff_state_c;
      ret_state_d = ret_state_q;
      bub_cnt_d   = bub_cnt_q;
      timer_d     = 8'd0;
      timeout_d   = timeout_q;
      if (bus.Mem_Stall) begin
         state_d = MEM_WAIT;
         case (state_q)
            RUN: begin
               ret_state_d = RUN;
               timer_d     = 8'd1;
            end
            BUBBLE: begin
               ret_state_d = BUBBLE;
               timer_d     = 8'd1;
            end
            default: timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
         endcase
         // timer_d counts consecutive stall cycles including this one.
         if ((MEM_TIMEOUT != 0) && (timer_d == 8'(MEM_TIMEOUT))) timeout_d = 1'b1;
      end else begin
         case (eff_state_c)
            RUN: begin
               if (lu_c && (LOAD_USE_CYCLES > 1)) begin
                  bub_cnt_d = 2'(LOAD_USE_CYCLES - 1);
                  state_d   = BUBBLE;
               end else begin
                  state_d = RUN;
               end
            end
            BUBBLE: begin
               bub_cnt_d = bub_cnt_q - 2'd1;
               state_d   = (bub_cnt_q == 2'd1) ? RUN : BUBBLE;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Output logic; reset forces the idle pattern.
   always_comb begin
      bus.PC_Write     = 1'b1;
      bus.IF_ID_Write  = 1'b1;
      bus.IF_ID_Flush  = 1'b0;
      bus.ID_EX_Bubble = 1'b0;
      bus.Pipe_Freeze  = 1'b0;
      bus.Mem_Timeout  = timeout_q && !rst_i;
      if (!rst_i) begin
         if (bus.Mem_Stall) begin
            bus.PC_Write    = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.Pipe_Freeze = 1'b1;
         end else begin
            case (eff_state_c)
               RUN: begin
                  if (lu_c) begin
                     bus.PC_Write     = 1'b0;
                     bus.IF_ID_Write  = 1'b0;
                     bus.ID_EX_Bubble = 1'b1;
                  end else if (bus.Branch_Taken) begin
                     bus.IF_ID_Flush = 1'b1;
                  end
               end
               BUBBLE: begin
                  bus.PC_Write     = 1'b0;
                  bus.IF_ID_Write  = 1'b0;
                  bus.ID_EX_Bubble = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef HAZARD_PERF_EN
   hazard_perf_counters u_perf (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .bubble_i       (bus.ID_EX_Bubble),
      .freeze_i       (bus.Pipe_Freeze),
      .flush_i        (bus.IF_ID_Flush),
      .loaduse_cnt_o  (Perf_LoadUse_Cnt),
      .memstall_cnt_o (Perf_MemStall_Cnt),
      .flush_cnt_o    (Perf_Flush_Cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (LOAD_USE_CYCLES=2, MEM_TIMEOUT=4).
// Counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_stall_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   // Output vector: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze}
   localparam logic [31:0] IDLE   = 32'h18;
   localparam logic [31:0] STALL  = 32'h02;
   localparam logic [31:0] FREEZE = 32'h01;
   localparam logic [31:0] FLUSH  = 32'h1C;

   always #5 clk = ~clk;

   hazard_stall_controller_if hif ();

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_lu, perf_ms, perf_fl;
`endif

   hazard_stall_controller #(
      .LOAD_USE_CYCLES (2),
      .MEM_TIMEOUT     (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (hif.slave)
`ifdef HAZARD_PERF_EN
      ,
      .Perf_LoadUse_Cnt  (perf_lu),
      .Perf_MemStall_Cnt (perf_ms),
      .Perf_Flush_Cnt    (perf_fl)
`endif
   );

   function automatic logic [31:0] outv();
      return {27'd0, hif.PC_Write, hif.IF_ID_Write, hif.IF_ID_Flush,
              hif.ID_EX_Bubble, hif.Pipe_Freeze};
   endfunction

   // Drive one cycle of inputs just after the falling edge, then let them settle.
   task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic br,
                        input logic ms);
      @(negedge clk);
      rst               = r;
      hif.IF_ID_RS1     = rs1;
      hif.IF_ID_RS2     = rs2;
      hif.ID_EX_RD      = rd;
      hif.ID_EX_MemRead = mr;
      hif.Branch_Taken  = br;
      hif.Mem_Stall     = ms;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      hif.IF_ID_RS1 = '0; hif.IF_ID_RS2 = '0; hif.ID_EX_RD = '0;
      hif.ID_EX_MemRead = 1'b0; hif.Branch_Taken = 1'b0; hif.Mem_Stall = 1'b0;

      // Reset forces idle even with a hazard present.
      drive(1, 0, 5, 5, 1, 0, 0); chk("reset_outs", outv(), IDLE);
      chk("reset_timeout", 32'(hif.Mem_Timeout), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0); chk("idle", outv(), IDLE);

      // Load-use on RS2: two bubble cycles then idle.
      drive(0, 0, 5, 5, 1, 0, 0); chk("lu_rs2_c1", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 0); chk("lu_rs2_c2", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 0); chk("lu_rs2_done", outv(), IDLE);

      // Load into x0 is never a hazard.
      drive(0, 0, 0, 0, 1, 0, 0); chk("lu_x0", outv(), IDLE);

      // Branch with load-use: stall only; branch ignored in BUBBLE, flushes after.
      drive(0, 7, 0, 7, 1, 1, 0); chk("lu_br_c1", outv(), STALL);
      drive(0, 0, 0, 0, 0, 1, 0); chk("lu_br_c2", outv(), STALL);
      drive(0, 0, 0, 0, 0, 1, 0); chk("br_flush", outv(), FLUSH);
      drive(0, 0, 0, 0, 0, 0, 0); chk("br_done", outv(), IDLE);

      // Memory stall during the second bubble cycle.
      drive(0, 0, 3, 3, 1, 0, 0); chk("bms_b1", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 1); chk("bms_f1", outv(), FREEZE);
      drive(0, 0, 0, 0, 0, 0, 1); chk("bms_f2", outv(), FREEZE);
      drive(0, 0, 0, 0, 0, 0, 1); chk("bms_f3", outv(), FREEZE);
      chk("bms_no_timeout", 32'(hif.Mem_Timeout), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0); chk("bms_b2", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 0); chk("bms_run", outv(), IDLE);

      // Mem_Stall outranks a coincident load-use (RS1 match); LU resumes afterwards.
      drive(0, 9, 0, 9, 1, 0, 1); chk("prio_freeze", outv(), FREEZE);
      drive(0, 9, 0, 9, 1, 0, 0); chk("prio_lu_c1", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 0); chk("prio_lu_c2", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 0); chk("prio_done", outv(), IDLE);

      // Watchdog: six stall cycles, timeout visible from the fifth.
      for (int i = 1; i <= 6; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1);
         chk($sformatf("to_freeze_%0d", i), outv(), FREEZE);
         chk($sformatf("to_flag_%0d", i), 32'(hif.Mem_Timeout), (i >= 5) ? 32'd1 : 32'd0);
      end
      drive(0, 0, 0, 0, 0, 0, 0); chk("to_release", outv(), IDLE);
      chk("to_sticky", 32'(hif.Mem_Timeout), 32'd1);
      drive(1, 0, 4, 4, 1, 0, 1); chk("to_rst_outs", outv(), IDLE);
      chk("to_rst_flag", 32'(hif.Mem_Timeout), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0); chk("to_cleared", 32'(hif.Mem_Timeout), 32'd0);

      // Reset mid-BUBBLE leaves no residual stall.
      drive(0, 0, 6, 6, 1, 0, 0); chk("rb_stall", outv(), STALL);
      drive(1, 0, 0, 0, 0, 0, 0); chk("rb_rst", outv(), IDLE);
      drive(0, 0, 0, 0, 0, 0, 0); chk("rb_after", outv(), IDLE);

      // Reset mid-MEM_WAIT leaves no residual freeze.
      drive(0, 0, 0, 0, 0, 0, 1); chk("rm_freeze", outv(), FREEZE);
      drive(1, 0, 0, 0, 0, 0, 1); chk("rm_rst", outv(), IDLE);
      drive(0, 0, 0, 0, 0, 0, 0); chk("rm_after", outv(), IDLE);

      // 2 bubbles + 3 freezes + 1 flush from a clean count.
      drive(0, 2, 0, 2, 1, 0, 0); chk("pf_b1", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 0); chk("pf_b2", outv(), STALL);
      drive(0, 0, 0, 0, 0, 0, 1); chk("pf_f1", outv(), FREEZE);
      drive(0, 0, 0, 0, 0, 0, 1); chk("pf_f2", outv(), FREEZE);
      drive(0, 0, 0, 0, 0, 0, 1); chk("pf_f3", outv(), FREEZE);
      drive(0, 0, 0, 0, 0, 1, 0); chk("pf_flush", outv(), FLUSH);
      drive(0, 0, 0, 0, 0, 0, 0); chk("pf_idle", outv(), IDLE);
`ifdef HAZARD_PERF_EN
      chk("perf_loaduse", perf_lu, 32'd2);
      chk("perf_memstall", perf_ms, 32'd3);
      chk("perf_flush", perf_fl, 32'd1);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("perf_reset", perf_lu | perf_ms | perf_fl, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
